riscv_ahb3_ext_sram: RTL and testbench

AHB3-Lite single-slave SRAM model with an optional external-memory timing profile. One instance attaches to each tile's ahb3_ext_* master port of the 4D-mesh MPSoC top, one per node. It decodes and range-checks each transfer, inserts a parameterised number of wait states, performs byte, halfword and word accesses, and returns the two-cycle AHB ERROR response on illegal accesses.

---
 rtl/riscv_ahb3_ext_sram.sv | 138 +++++++++++++
 tb/tb_riscv_ahb3_ext_sram.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_ahb3_ext_sram.sv
// AHB3-Lite single-slave SRAM model with programmable data-phase wait states
// and the two-cycle ERROR response for out-of-range or misaligned transfers.
//
// state | meaning
// IDLE  | no data phase pending
// DATA  | OKAY data phase, counting down wait states
// ERR1  | first ERROR cycle (hready low)
// ERR2  | second ERROR cycle (hready high)
module riscv_ahb3_ext_sram #(
  parameter int              PLEN        = 32,
  parameter int              XLEN        = 32,
  parameter int              MEM_DEPTH   = 1024,
  parameter int              WAIT_STATES = 0,
  parameter logic [PLEN-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ahb3_hsel,
  input  logic [PLEN-1:0] ahb3_haddr,
  input  logic [XLEN-1:0] ahb3_hwdata,
  input  logic            ahb3_hwrite,
  input  logic [2:0]      ahb3_hsize,
  input  logic [2:0]      ahb3_hburst,
  input  logic [3:0]      ahb3_hprot,
  input  logic [1:0]      ahb3_htrans,
  input  logic            ahb3_hmastlock,
  output logic [XLEN-1:0] ahb3_hrdata,
  output logic            ahb3_hready,
  output logic            ahb3_hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LANES = XLEN / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lo_q;
  logic [2:0]       size_q;
  logic             write_q;
  logic             err_q;
  logic [3:0]       cnt_q;

  logic [XLEN-1:0]  mem [MEM_DEPTH];

  logic [PLEN-1:0]  off;
  logic             accept;
  logic             range_err;
  logic             size_err;
  logic             acc_err;
  logic             done;
  logic             mem_we;
  logic [LANES-1:0] be;

  logic unused_inputs;
  assign unused_inputs = ^{ahb3_hburst, ahb3_hprot, ahb3_hmastlock, ahb3_htrans[0], off[1:0], err_q};

  // Offset wraps at PLEN bits, so addresses below BASE_ADDR land far out of range.
  assign off       = ahb3_haddr - BASE_ADDR;
  assign range_err = |off[PLEN-1:IDX_W+2];
  assign size_err  = (ahb3_hsize > 3'd2) ||
                     (ahb3_hsize == 3'd1 && ahb3_haddr[0]) ||
                     (ahb3_hsize == 3'd2 && ahb3_haddr[1:0] != 2'b00);
  assign acc_err   = range_err || size_err;
  assign accept    = ahb3_hsel && ahb3_htrans[1] && ahb3_hready;

  assign ahb3_hready = (state == ST_ERR1) ? 1'b0 :
                       (state == ST_DATA) ? (cnt_q == 4'd0) : 1'b1;
  assign ahb3_hresp  = (state == ST_ERR1) || (state == ST_ERR2);
  assign done        = (state == ST_DATA) && (cnt_q == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = acc_err ? ST_ERR1 : ST_DATA;
      ST_DATA: begin
        if (cnt_q == 4'd0) begin
          if (accept) state_nxt = acc_err ? ST_ERR1 : ST_DATA;
          else        state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: begin
        if (accept) state_nxt = acc_err ? ST_ERR1 : ST_DATA;
        else        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q   <= off[IDX_W+1:2];
        lo_q    <= ahb3_haddr[1:0];
        size_q  <= ahb3_hsize;
        write_q <= ahb3_hwrite;
        err_q   <= acc_err;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state == ST_DATA && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    be = '0;
    case (size_q)
      3'd0:    be[lo_q] = 1'b1;
      3'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = '1;
    endcase
  end

  // Reset forces IDLE asynchronously, so an aborted write never reaches this edge.
  assign mem_we = done && write_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= ahb3_hwdata[8*i +: 8];
      end
    end
  end

  assign ahb3_hrdata = (state == ST_DATA && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_riscv_ahb3_ext_sram.sv
// Directed bench: one slave with zero wait states and one with three, sharing
// the master-side signals and selected through their own hsel.
module tb_riscv_ahb3_ext_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel3;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3, hresp0, hresp3;
  logic        cur3;
  logic [31:0] rd;
  logic        rdy, resp;
  int          total = 0;
  int          bad = 0;
  int          n;

  always #5 clk = ~clk;

  riscv_ahb3_ext_sram #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ahb3_hsel(hsel0), .ahb3_haddr(haddr),
    .ahb3_hwdata(hwdata), .ahb3_hwrite(hwrite), .ahb3_hsize(hsize),
    .ahb3_hburst(3'd0), .ahb3_hprot(4'd0), .ahb3_htrans(htrans),
    .ahb3_hmastlock(1'b0), .ahb3_hrdata(hrdata0), .ahb3_hready(hready0),
    .ahb3_hresp(hresp0));

  riscv_ahb3_ext_sram #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ahb3_hsel(hsel3), .ahb3_haddr(haddr),
    .ahb3_hwdata(hwdata), .ahb3_hwrite(hwrite), .ahb3_hsize(hsize),
    .ahb3_hburst(3'd0), .ahb3_hprot(4'd0), .ahb3_htrans(htrans),
    .ahb3_hmastlock(1'b0), .ahb3_hrdata(hrdata3), .ahb3_hready(hready3),
    .ahb3_hresp(hresp3));

  assign rd   = cur3 ? hrdata3 : hrdata0;
  assign rdy  = cur3 ? hready3 : hready0;
  assign resp = cur3 ? hresp3  : hresp0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit act, input logic [31:0] a, input bit w, input logic [2:0] sz);
    hsel0  = act && !cur3;
    hsel3  = act && cur3;
    htrans = act ? 2'b10 : 2'b00;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts data-phase cycles with hready low; stops at the completing cycle.
  task automatic wait_low(output int cnt);
    cnt = 0;
    while (rdy !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cur3 = 1'b0;
    hwdata = '0;
    drive(1, 32'h10, 1, 3'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hready0", 32'(hready0), 32'd1);
      chk("rst_hresp0", 32'(hresp0), 32'd0);
      chk("rst_hrdata0", hrdata0, 32'h0);
      chk("rst_hready3", 32'(hready3), 32'd1);
    end
    rst_n = 1'b1;

    // word round trip, read address phase overlapping the write data phase
    tick();
    hwdata = 32'hDEADBEEF;
    drive(1, 32'h10, 0, 3'd2);
    chk("rt_wr_hready", 32'(rdy), 32'd1);
    chk("rt_wr_hrdata", rd, 32'h0);
    tick();
    drive(0, 32'h0, 0, 3'd0);
    chk("rt_rd_data", rd, 32'hDEADBEEF);
    chk("rt_rd_hready", 32'(rdy), 32'd1);
    chk("rt_rd_hresp", 32'(resp), 32'd0);
    tick();
    chk("rt_idle_hrdata", rd, 32'h0);

    // byte and halfword lanes, junk on unused lanes
    drive(1, 32'h20, 1, 3'd2);
    tick();
    hwdata = 32'h0;
    drive(1, 32'h22, 1, 3'd0);
    tick();
    hwdata = 32'h11AB2233;
    drive(1, 32'h20, 1, 3'd1);
    tick();
    hwdata = 32'h55661234;
    drive(1, 32'h20, 0, 3'd2);
    tick();
    drive(0, 32'h0, 0, 3'd0);
    chk("lane_rd_data", rd, 32'h00AB1234);
    tick();

    // error responses, word 0 must survive the misaligned write
    drive(1, 32'h0, 1, 3'd2);
    tick();
    hwdata = 32'hCAFEF00D;
    drive(1, 32'h1000, 0, 3'd2);
    tick();
    drive(1, 32'h2, 1, 3'd2);
    chk("oor_err1_hready", 32'(rdy), 32'd0);
    chk("oor_err1_hresp", 32'(resp), 32'd1);
    tick();
    chk("oor_err2_hready", 32'(rdy), 32'd1);
    chk("oor_err2_hresp", 32'(resp), 32'd1);
    tick();
    hwdata = 32'hFFFFFFFF;
    drive(0, 32'h0, 0, 3'd0);
    chk("mis_err1_hready", 32'(rdy), 32'd0);
    chk("mis_err1_hresp", 32'(resp), 32'd1);
    tick();
    chk("mis_err2_hready", 32'(rdy), 32'd1);
    chk("mis_err2_hresp", 32'(resp), 32'd1);
    tick();
    chk("err_after_hresp", 32'(resp), 32'd0);
    drive(1, 32'h0, 0, 3'd2);
    tick();
    drive(0, 32'h0, 0, 3'd0);
    chk("err_word0_data", rd, 32'hCAFEF00D);
    tick();

    // three wait states on the second slave
    cur3 = 1'b1;
    drive(1, 32'h0, 1, 3'd2);
    tick();
    hwdata = 32'hA5A5A5A5;
    drive(1, 32'h0, 0, 3'd2);
    wait_low(n);
    chk("ws_wr_stall", 32'(n), 32'd3);
    chk("ws_wr_hready", 32'(rdy), 32'd1);
    tick();
    drive(0, 32'h0, 0, 3'd0);
    wait_low(n);
    chk("ws_rd_stall", 32'(n), 32'd3);
    chk("ws_rd_data", rd, 32'hA5A5A5A5);
    tick();

    // reset in the second wait cycle of a write
    drive(1, 32'h8, 1, 3'd2);
    tick();
    hwdata = 32'h22222222;
    drive(0, 32'h0, 0, 3'd0);
    wait_low(n);
    tick();
    drive(1, 32'h8, 1, 3'd2);
    tick();
    hwdata = 32'h11111111;
    drive(0, 32'h0, 0, 3'd0);
    tick();
    chk("mid_pre_hready", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hready", 32'(rdy), 32'd1);
    chk("mid_rst_hresp", 32'(resp), 32'd0);
    chk("mid_rst_hrdata", rd, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1, 32'h8, 0, 3'd2);
    tick();
    drive(0, 32'h0, 0, 3'd0);
    wait_low(n);
    chk("mid_rd_stall", 32'(n), 32'd3);
    chk("mid_rd_data", rd, 32'h22222222);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
